ascon_hash_ctrl: RTL and testbench

ASCON_HASH_CTRL -- requirements
Module: ascon_hash_ctrl

---
 rtl/ascon_hash_ctrl_if.sv | 23 ++
 rtl/ascon_hash_ctrl.sv | 146 ++++++++++++++
 tb/tb_ascon_hash_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_hash_ctrl_if.sv
// Message-in / digest-out stream bundle for ascon_hash_ctrl.
// Both directions are valid/ready: a word moves on a rising clk edge where valid and ready are both high; the source holds data stable while valid && !ready.
interface ascon_hash_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic [2:0]  in_bytes;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;

  modport master (
    output in_valid, in_data, in_last, in_bytes, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ascon_hash_ctrl.sv
// Ascon-Hash sequencer: absorbs 64-bit beats and squeezes the digest around an external p12 core.
// Define ASCON_HASH_XOF_EN for XOF mode (out_words port, XOF IV, per-message squeeze length).
module ascon_hash_ctrl #(
  parameter int NUM_ROUNDS = 12,
  parameter int OUT_BLOCKS = 4
) (
  input  logic                clk,
  input  logic                rst,
  ascon_hash_ctrl_if.slave    bus,
`ifdef ASCON_HASH_XOF_EN
  input  logic [7:0]          out_words,
`endif
  output logic                busy,
  output logic                perm_load,
  output logic                perm_run,
  output logic [63:0]         perm_s0_init,
  output logic [63:0]         perm_s1_init,
  output logic [63:0]         perm_s2_init,
  output logic [63:0]         perm_s3_init,
  output logic [63:0]         perm_s4_init,
  input  logic [63:0]         perm_s0,
  input  logic [63:0]         perm_s1,
  input  logic [63:0]         perm_s2,
  input  logic [63:0]         perm_s3,
  input  logic [63:0]         perm_s4,
  input  logic                perm_done,
  output logic [2:0]          dbg_state
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] INIT    = 3'd1;
  localparam logic [2:0] PERM    = 3'd2;
  localparam logic [2:0] ABSORB  = 3'd3;
  localparam logic [2:0] SQUEEZE = 3'd4;

`ifdef ASCON_HASH_XOF_EN
  localparam logic [63:0] IV = 64'h00400c0000000000;
`else
  localparam logic [63:0] IV = 64'h00400c0000000100;
`endif

  if (NUM_ROUNDS != 12) begin : g_rounds_check
    $error("ascon_hash_ctrl: NUM_ROUNDS must be 12");
  end

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic        last_seen;
  logic [7:0]  word_cnt;
  logic [7:0]  last_idx;
  logic        in_fire;
  logic        out_fire;
  logic        final_word;
  logic [63:0] pad_mask;
  logic [63:0] pad_byte;
  logic [63:0] block;

  assign in_fire    = (state == ABSORB) && bus.in_valid;
  assign out_fire   = (state == SQUEEZE) && bus.out_ready;
  assign final_word = (word_cnt == last_idx);

  // Last beat keeps its leading in_bytes bytes, then the 0x80 pad byte.
  always_comb begin
    pad_mask = ~(64'hffff_ffff_ffff_ffff >> {bus.in_bytes, 3'b000});
    pad_byte = 64'h80 << (6'd56 - {bus.in_bytes, 3'b000});
    block    = bus.in_last ? ((bus.in_data & pad_mask) | pad_byte) : bus.in_data;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = INIT;
      INIT:    state_nxt = PERM;
      PERM:    if (perm_done) state_nxt = last_seen ? SQUEEZE : ABSORB;
      ABSORB:  if (in_fire) state_nxt = PERM;
      SQUEEZE: if (out_fire) state_nxt = final_word ? IDLE : PERM;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_seen <= 1'b0;
      word_cnt  <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == INIT) begin
        last_seen <= 1'b0;
        word_cnt  <= 8'd0;
      end
      if (in_fire && bus.in_last) last_seen <= 1'b1;
      // Saturate rather than wrap so a long XOF squeeze cannot alias word 0.
      if (out_fire && (word_cnt != 8'hff)) word_cnt <= word_cnt + 8'd1;
    end
  end

`ifdef ASCON_HASH_XOF_EN
  logic first_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_beat <= 1'b0;
      last_idx   <= 8'(OUT_BLOCKS - 1);
    end else begin
      if (state == INIT) first_beat <= 1'b1;
      if (in_fire) begin
        first_beat <= 1'b0;
        if (first_beat) last_idx <= (out_words == 8'd0) ? 8'd0 : out_words - 8'd1;
      end
    end
  end
`else
  assign last_idx = 8'(OUT_BLOCKS - 1);
`endif

  assign bus.in_ready  = (state == ABSORB);
  assign bus.out_valid = (state == SQUEEZE);
  assign bus.out_last  = (state == SQUEEZE) && final_word;
  assign bus.out_data  = (state == SQUEEZE) ? perm_s0 : 64'd0;
  assign perm_run      = (state == PERM);
  assign busy          = (state != IDLE);
  assign perm_load     = (state == INIT) || in_fire || (out_fire && !final_word);
  assign dbg_state     = state;

  // Squeeze reloads reuse the current state; absorb folds the block into the rate word.
  always_comb begin
    perm_s0_init = 64'd0;
    perm_s1_init = 64'd0;
    perm_s2_init = 64'd0;
    perm_s3_init = 64'd0;
    perm_s4_init = 64'd0;
    case (state)
      INIT: perm_s0_init = IV;
      ABSORB, SQUEEZE: begin
        perm_s0_init = (state == ABSORB) ? (perm_s0 ^ block) : perm_s0;
        perm_s1_init = perm_s1;
        perm_s2_init = perm_s2;
        perm_s3_init = perm_s3;
        perm_s4_init = perm_s4;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ascon_hash_ctrl.sv
// Bench for ascon_hash_ctrl: behavioural Ascon p12 core on the perm ports plus a digest scoreboard.
// Build with ASCON_HASH_XOF_EN defined to exercise the XOF variant.
module tb_ascon_hash_ctrl;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_PERM   = 3'd2;
`ifdef ASCON_HASH_XOF_EN
  localparam logic [63:0] IV_EXP  = 64'h00400c0000000000;
`else
  localparam logic [63:0] IV_EXP  = 64'h00400c0000000100;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ascon_hash_ctrl_if bus_if ();
  logic        busy, perm_load, perm_run, perm_done;
  logic [63:0] perm_s0_init, perm_s1_init, perm_s2_init, perm_s3_init, perm_s4_init;
  logic [63:0] perm_s0, perm_s1, perm_s2, perm_s3, perm_s4;
  logic [2:0]  dbg_state;
`ifdef ASCON_HASH_XOF_EN
  logic [7:0]  out_words;
`endif

  ascon_hash_ctrl #(.NUM_ROUNDS(12), .OUT_BLOCKS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus_if),
`ifdef ASCON_HASH_XOF_EN
    .out_words(out_words),
`endif
    .busy(busy), .perm_load(perm_load), .perm_run(perm_run),
    .perm_s0_init(perm_s0_init), .perm_s1_init(perm_s1_init), .perm_s2_init(perm_s2_init),
    .perm_s3_init(perm_s3_init), .perm_s4_init(perm_s4_init),
    .perm_s0(perm_s0), .perm_s1(perm_s1), .perm_s2(perm_s2), .perm_s3(perm_s3), .perm_s4(perm_s4),
    .perm_done(perm_done), .dbg_state(dbg_state)
  );

  // Ascon permutation reference
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input int i);
    logic [63:0] x0, x1, x2, x3, x4, y0, y1, y2, y3, y4;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ {56'd0, 8'(240 - 15 * i)};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    y0 = x0 ^ (~x1 & x2);
    y1 = x1 ^ (~x2 & x3);
    y2 = x2 ^ (~x3 & x4);
    y3 = x3 ^ (~x4 & x0);
    y4 = x4 ^ (~x0 & x1);
    y1 = y1 ^ y0; y0 = y0 ^ y4; y3 = y3 ^ y2; y2 = ~y2;
    x0 = y0 ^ ror(y0, 19) ^ ror(y0, 28);
    x1 = y1 ^ ror(y1, 61) ^ ror(y1, 39);
    x2 = y2 ^ ror(y2, 1)  ^ ror(y2, 6);
    x3 = y3 ^ ror(y3, 10) ^ ror(y3, 17);
    x4 = y4 ^ ror(y4, 7)  ^ ror(y4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] p12(input logic [319:0] s);
    logic [319:0] r;
    r = s;
    for (int i = 0; i < 12; i++) r = ascon_round(r, i);
    return r;
  endfunction

  function automatic logic [63:0] pad_block(input logic [63:0] d, input int nb);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < nb) r[63 - 8 * k -: 8] = d[63 - 8 * k -: 8];
      else if (k == nb) r[63 - 8 * k -: 8] = 8'h80;
    end
    return r;
  endfunction

  // Paired permutation core: load clears the round count, one round per perm_run cycle.
  logic [319:0] m_st;
  int           m_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st  <= '0;
      m_cnt <= 12;
    end else if (perm_load) begin
      m_st  <= {perm_s0_init, perm_s1_init, perm_s2_init, perm_s3_init, perm_s4_init};
      m_cnt <= 0;
    end else if (perm_run && m_cnt < 12) begin
      m_st  <= ascon_round(m_st, m_cnt);
      m_cnt <= m_cnt + 1;
    end
  end
  assign {perm_s0, perm_s1, perm_s2, perm_s3, perm_s4} = m_st;
  assign perm_done = perm_run && (m_cnt == 11);

  // scoreboard
  logic [63:0] exp_q[$];
  int          passed = 0;
  int          total  = 0;
  logic [63:0] msg_w[8];
  int          msg_n;
  logic [63:0] last_d;
  logic [2:0]  last_b;
  logic        cap_load;
  logic [63:0] cap_init0, cap_s0, cap_init1, cap_s1;

  task automatic push_model(input logic [63:0] iv, input int nout);
    logic [319:0] s;
    s = p12({iv, 256'd0});
    for (int k = 0; k < msg_n; k++) begin
      s[319:256] = s[319:256] ^ msg_w[k];
      s = p12(s);
    end
    s[319:256] = s[319:256] ^ pad_block(last_d, int'(last_b));
    s = p12(s);
    for (int j = 0; j < nout; j++) begin
      exp_q.push_back(s[319:256]);
      if (j < nout - 1) s = p12(s);
    end
  endtask

  task automatic push_empty_digest();
`ifdef ASCON_HASH_XOF_EN
    msg_n = 0; last_b = 3'd0;
    push_model(IV_EXP, 4);
`else
    exp_q.push_back(64'h7346bc14f036e87a);
    exp_q.push_back(64'he03d0997913088f5);
    exp_q.push_back(64'hf68411434b3cf8b5);
    exp_q.push_back(64'h4fa796a80d251f91);
`endif
  endtask

  // driver tasks
  task automatic beat(input logic [63:0] d, input logic l, input logic [2:0] b);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b1; bus_if.in_data = d; bus_if.in_last = l; bus_if.in_bytes = b;
    @(negedge clk);
    while (bus_if.in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (bus_if.in_ready !== 1'b1) $display("FAIL in_ready_wait: got %b want 1 within 200 cycles", bus_if.in_ready);
    else begin
      passed++;
      cap_load = perm_load; cap_init0 = perm_s0_init; cap_s0 = perm_s0;
      cap_init1 = perm_s1_init; cap_s1 = perm_s1;
    end
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0; bus_if.in_data = '0; bus_if.in_last = 1'b0; bus_if.in_bytes = '0;
  endtask

  task automatic send_msg();
    for (int k = 0; k < msg_n; k++) beat(msg_w[k], 1'b0, 3'($urandom_range(0, 7)));
    beat(last_d, 1'b1, last_b);
  endtask

  task automatic collect(input int n, input int stall_idx, input bit rnd);
    int          got, guard;
    bit          stalled;
    logic [63:0] held, exp;
    got = 0; guard = 0; stalled = 0;
    while (got < n && guard < 5000) begin
      @(posedge clk); #1;
      if (got == stall_idx && !stalled) bus_if.out_ready = 1'b0;
      else bus_if.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      guard++;
      if (bus_if.out_valid && got == stall_idx && !stalled) begin
        held = bus_if.out_data;
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          total++;
          if (bus_if.out_data !== held || bus_if.out_valid !== 1'b1 || perm_load !== 1'b0)
            $display("FAIL stall_hold: data %h valid %b load %b want %h 1 0",
                     bus_if.out_data, bus_if.out_valid, perm_load, held);
          else passed++;
        end
        stalled = 1;
      end else if (bus_if.out_valid && bus_if.out_ready) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL digest_word%0d: got %h want nothing queued", got, bus_if.out_data);
        else begin
          exp = exp_q.pop_front();
          if (bus_if.out_data !== exp || bus_if.out_last !== 1'(got == n - 1) || bus_if.in_ready !== 1'b0)
            $display("FAIL digest_word%0d: data %h last %b in_ready %b want %h %b 0",
                     got, bus_if.out_data, bus_if.out_last, bus_if.in_ready, exp, 1'(got == n - 1));
          else passed++;
        end
        got++;
      end
    end
    total++;
    if (got < n) $display("FAIL digest_count: got %0d words want %0d", got, n);
    else passed++;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || dbg_state !== S_IDLE)
      $display("FAIL post_digest_idle: busy %b state %0d want 0 %0d", busy, dbg_state, S_IDLE);
    else passed++;
  endtask

  // scenarios
  task automatic test_reset();
    #12;
    total++;
    if ({bus_if.in_ready, bus_if.out_valid, bus_if.out_last, perm_load, perm_run, busy} !== 6'b0 ||
        dbg_state !== S_IDLE)
      $display("FAIL reset_flags: flags %b state %0d want 000000 %0d",
               {bus_if.in_ready, bus_if.out_valid, bus_if.out_last, perm_load, perm_run, busy}, dbg_state, S_IDLE);
    else passed++;
    total++;
    if ((bus_if.out_data | perm_s0_init | perm_s1_init | perm_s2_init | perm_s3_init | perm_s4_init) !== 64'd0)
      $display("FAIL reset_buses: or %h want 0",
               bus_if.out_data | perm_s0_init | perm_s1_init | perm_s2_init | perm_s3_init | perm_s4_init);
    else passed++;
  endtask

  task automatic test_init_timing();
    int k, runs;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (dbg_state !== S_IDLE || perm_load !== 1'b0)
      $display("FAIL init_idle: state %0d load %b want %0d 0", dbg_state, perm_load, S_IDLE);
    else passed++;
    @(negedge clk);
    total++;
    if (dbg_state !== S_INIT || perm_load !== 1'b1 || perm_s0_init !== IV_EXP || perm_s4_init !== 64'd0)
      $display("FAIL init_load: state %0d load %b s0 %h want %0d 1 %h", dbg_state, perm_load, perm_s0_init, S_INIT, IV_EXP);
    else passed++;
    k = 0; runs = 0;
    while (bus_if.in_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
      if (perm_run === 1'b1) runs++;
    end
    total++;
    if (k !== 13 || runs !== 12)
      $display("FAIL init_latency: in_ready after %0d cycles, perm_run %0d cycles want 13 12", k, runs);
    else passed++;
  endtask

  task automatic test_empty();
    push_empty_digest();
    beat({$urandom, $urandom}, 1'b1, 3'd0);
    collect(4, -1, 1'b0);
  endtask

  task automatic test_abc();
    msg_n = 0;
    last_d = {24'h616263, 40'({$urandom, $urandom})};
    last_b = 3'd3;
    push_model(IV_EXP, 4);
    send_msg();
    total++;
    if (cap_load !== 1'b1 || (cap_init0 ^ cap_s0) !== 64'h6162638000000000 || cap_init1 !== cap_s1)
      $display("FAIL abc_block: load %b block %h s1fb %h want 1 6162638000000000 %h",
               cap_load, cap_init0 ^ cap_s0, cap_init1, cap_s1);
    else passed++;
    collect(4, -1, 1'b1);
  endtask

  task automatic test_multi();
    logic [2:0] lbs[3];
    lbs = '{3'd7, 3'd0, 3'd5};
    for (int t = 0; t < 3; t++) begin
      msg_n = t + 1;
      for (int k = 0; k < msg_n; k++) msg_w[k] = {$urandom, $urandom};
      last_d = {$urandom, $urandom};
      last_b = lbs[t];
      push_model(IV_EXP, 4);
      send_msg();
      collect(4, -1, 1'b1);
    end
  endtask

  task automatic test_stall();
    push_empty_digest();
    beat({$urandom, $urandom}, 1'b1, 3'd0);
    collect(4, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 2; t++) begin
      msg_n = 2;
      msg_w[0] = {$urandom, $urandom};
      msg_w[1] = {$urandom, $urandom};
      last_d = {$urandom, $urandom};
      last_b = 3'($urandom_range(0, 7));
      push_model(IV_EXP, 4);
      send_msg();
      collect(4, -1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    beat({$urandom, $urandom}, 1'b0, 3'd0);
    beat({$urandom, $urandom}, 1'b0, 3'd0);
    repeat (3) @(posedge clk);
    total++;
    if (perm_run !== 1'b1 || dbg_state !== S_PERM)
      $display("FAIL mid_perm: run %b state %0d want 1 %0d", perm_run, dbg_state, S_PERM);
    else passed++;
    #3;
    rst = 1'b1;
    #1;
    total++;
    if ({bus_if.in_ready, bus_if.out_valid, bus_if.out_last, perm_load, perm_run, busy} !== 6'b0 ||
        (bus_if.out_data | perm_s0_init | perm_s1_init) !== 64'd0 || dbg_state !== S_IDLE)
      $display("FAIL mid_reset: flags %b state %0d want 000000 %0d",
               {bus_if.in_ready, bus_if.out_valid, bus_if.out_last, perm_load, perm_run, busy}, dbg_state, S_IDLE);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (dbg_state !== S_INIT || perm_load !== 1'b1 || bus_if.out_valid !== 1'b0)
      $display("FAIL restart_init: state %0d load %b valid %b want %0d 1 0",
               dbg_state, perm_load, bus_if.out_valid, S_INIT);
    else passed++;
    push_empty_digest();
    beat({$urandom, $urandom}, 1'b1, 3'd0);
    collect(4, -1, 1'b0);
  endtask

`ifdef ASCON_HASH_XOF_EN
  task automatic test_xof();
    out_words = 8'd0;
    msg_n = 0;
    last_d = {$urandom, $urandom};
    last_b = 3'($urandom_range(0, 7));
    push_model(IV_EXP, 1);
    send_msg();
    collect(1, -1, 1'b0);
    out_words = 8'd2;
    msg_n = 1;
    msg_w[0] = {$urandom, $urandom};
    push_model(IV_EXP, 2);
    beat(msg_w[0], 1'b0, 3'd0);
    out_words = 8'd9;
    beat(last_d, 1'b1, last_b);
    collect(2, -1, 1'b1);
    out_words = 8'd4;
  endtask
`endif

  initial begin
    bus_if.in_valid = 1'b0; bus_if.in_data = '0; bus_if.in_last = 1'b0;
    bus_if.in_bytes = '0; bus_if.out_ready = 1'b0;
`ifdef ASCON_HASH_XOF_EN
    out_words = 8'd4;
`endif
    test_reset();
    test_init_timing();
    test_empty();
    test_abc();
    test_multi();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef ASCON_HASH_XOF_EN
    test_xof();
`endif
    total++;
    if (exp_q.size() != 0) $display("FAIL leftover_expected: %0d words left want 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
